// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when an instruction actually reads src and src names the given destination.
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// With HAZARD_STATS_EN defined it also carries the 32-bit event counters.
interface hazard_ctrl_if;

  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       uses_rs1_ID;
  logic       uses_rs2_ID;
  logic       MemRead_EX;
  logic [4:0] wrin_EX;
  logic       branch_taken_EX;
  logic       mem_busy;

  logic       PCWrite;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Write;
  logic       ID_EX_Flush;
  logic       EX_MEM_Write;
  logic [1:0] state_o;
  logic       mem_timeout;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] wait_cnt;
`endif

  modport master (
    output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID,
    output MemRead_EX, wrin_EX, branch_taken_EX, mem_busy,
`ifdef HAZARD_STATS_EN
    input  stall_cnt, flush_cnt, wait_cnt,
`endif
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
    input  EX_MEM_Write, state_o, mem_timeout
  );

  modport slave (
    input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID,
    input  MemRead_EX, wrin_EX, branch_taken_EX, mem_busy,
`ifdef HAZARD_STATS_EN
    output stall_cnt, flush_cnt, wait_cnt,
`endif
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
    output EX_MEM_Write, state_o, mem_timeout
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare: ID source registers against the EX load destination.
// Standalone so the forwarding unit can share the same register compare.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       uses_rs1_ID,
  input  logic       uses_rs2_ID,
  input  logic       MemRead_EX,
  input  logic [4:0] wrin_EX,
  output logic       luh
);

  logic [4:0] src [2];
  logic [1:0] uses;
  logic [1:0] hit;

  assign src[0]  = rs1_ID;
  assign src[1]  = rs2_ID;
  assign uses[0] = uses_rs1_ID;
  assign uses[1] = uses_rs2_ID;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign hit[gi] = src_match(uses[gi], src[gi], wrin_EX);
  end

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign luh = MemRead_EX && (wrin_EX != REG_ZERO) && (|hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: resolves load-use, taken-branch and data-memory-wait hazards at the ID/EX boundary.
// Define HAZARD_STATS_EN to add the stall/flush/wait event counters on the interface.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  hazard_ctrl_if.slave hz
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT   = 8'(MAX_WAIT);

  hz_state_t  state_reg, state_next;
  logic [2:0] flush_left_reg, flush_left_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_reg, timeout_next;

  logic luh;
  logic freeze, flush_phase, flush_cont, branch_start, stall;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;

  hazard_detect u_detect (
    .rs1_ID      (hz.rs1_ID),
    .rs2_ID      (hz.rs2_ID),
    .uses_rs1_ID (hz.uses_rs1_ID),
    .uses_rs2_ID (hz.uses_rs2_ID),
    .MemRead_EX  (hz.MemRead_EX),
    .wrin_EX     (hz.wrin_EX),
    .luh         (luh)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= RUN;
      flush_left_reg <= '0;
      wait_cnt_reg   <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      flush_left_reg <= flush_left_next;
      wait_cnt_reg   <= wait_cnt_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    flush_left_next = flush_left_reg;
    wait_cnt_next   = wait_cnt_reg;
    timeout_next    = timeout_reg;

    // A freeze interrupting a flush keeps flush_left_reg, so the owed flushes resume on exit.
    flush_phase  = (state_reg == BR_FLUSH) ||
                   ((state_reg == MEM_WAIT) && (flush_left_reg != 3'd0));
    freeze       = hz.mem_busy;
    flush_cont   = !freeze && flush_phase;
    branch_start = !freeze && !flush_phase && hz.branch_taken_EX;
    stall        = !freeze && !flush_phase && !hz.branch_taken_EX && luh;

    if (freeze) begin
      state_next = MEM_WAIT;
      if (state_reg != MEM_WAIT) begin
        wait_cnt_next = 8'd1;
      end else if (wait_cnt_reg != 8'hFF) begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
      end
    end else begin
      wait_cnt_next = '0;
      if (flush_cont) begin
        if (flush_left_reg <= 3'd1) begin
          state_next      = RUN;
          flush_left_next = '0;
        end else begin
          state_next      = BR_FLUSH;
          flush_left_next = flush_left_reg - 3'd1;
        end
      end else if (branch_start && (FLUSH_CYCLES > 1)) begin
        state_next      = BR_FLUSH;
        flush_left_next = FLUSH_RELOAD;
      end else begin
        state_next      = RUN;
        flush_left_next = '0;
      end
    end

    timeout_next = timeout_reg || (freeze && (wait_cnt_next >= WAIT_LIMIT));

    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;

    // Reset forces the pass-through controls regardless of inputs.
    if (!RESET) begin
      if (freeze) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
      end else if (flush_cont || branch_start) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign hz.PCWrite      = pc_write;
  assign hz.IF_ID_Write  = if_id_write;
  assign hz.IF_ID_Flush  = if_id_flush;
  assign hz.ID_EX_Write  = id_ex_write;
  assign hz.ID_EX_Flush  = id_ex_flush;
  assign hz.EX_MEM_Write = ex_mem_write;
  assign hz.state_o      = state_reg;
  assign hz.mem_timeout  = timeout_reg;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg, freeze_cnt_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
    end else begin
      if (stall)                      stall_cnt_reg  <= stall_cnt_reg + 32'd1;
      if (flush_cont || branch_start) flush_cnt_reg  <= flush_cnt_reg + 32'd1;
      if (freeze)                     freeze_cnt_reg <= freeze_cnt_reg + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_reg;
  assign hz.flush_cnt = flush_cnt_reg;
  assign hz.wait_cnt  = freeze_cnt_reg;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. It is the consumer and controller of the ID/EX boundary.
- Reads EX-stage control (MemRead_EX, wrin_EX, branch outcome) and ID-stage source registers.
- Drives write-enable and flush controls back into the PC, IF/ID, ID/EX and EX/MEM registers to resolve three hazards: load-use, taken branch and data-memory wait.
- Holds a small FSM, a flush counter and a memory-wait watchdog.

Parameters:
- FLUSH_CYCLES, 1, total cycles IF/ID and ID/EX are flushed after a taken branch (1..7).
- MAX_WAIT, 16, MEM_WAIT cycles after which mem_timeout sets (1..255).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- rs1_ID  in  5  source reg 1 of the instruction in ID.
- rs2_ID  in  5  source reg 2 of the instruction in ID.
- uses_rs1_ID  in  1  ID instruction reads rs1.
- uses_rs2_ID  in  1  ID instruction reads rs2.
- MemRead_EX  in  1  EX instruction is a load.
- wrin_EX  in  5  destination reg of the EX instruction.
- branch_taken_EX  in  1  EX branch/jump resolved taken this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- PCWrite  out  1  PC register enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  IF/ID register loads NOP.
- ID_EX_Write  out  1  ID/EX register enable.
- ID_EX_Flush  out  1  ID/EX register loads all-zero controls (bubble).
- EX_MEM_Write  out  1  EX/MEM register enable.
- state_o  out  2  current FSM state (RUN=0, BR_FLUSH=1, MEM_WAIT=2).
- mem_timeout  out  1  sticky: a memory wait exceeded MAX_WAIT.

Behaviour:
- Reset (async, RESET=1):
  - state=RUN, flush counter=0, wait counter=0, mem_timeout=0.
  - Outputs during reset: all *_Write=1, all flushes=0.
- Control outputs are combinational from state and inputs, so they act in the same cycle. State, counters and mem_timeout are registered.
- Load-use hazard (luh):
  - luh = MemRead_EX && wrin_EX!=0 && ((uses_rs1_ID && rs1_ID==wrin_EX) || (uses_rs2_ID && rs2_ID==wrin_EX)).
- Priority in RUN: mem_busy > branch_taken_EX > luh.
- RUN:
  - mem_busy: PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write all 0; no flush. Next state MEM_WAIT, wait counter=1.
  - else branch_taken_EX: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1 (target loads). If FLUSH_CYCLES>1, next state BR_FLUSH with counter=FLUSH_CYCLES-1; else stay in RUN.
  - else luh: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Stay in RUN; exactly one bubble, because the load leaves EX next cycle.
  - else: all writes 1, no flush.
- BR_FLUSH:
  - IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1. Counter decrements each cycle; return to RUN when it reaches 1.
  - luh is ignored (the ID instruction is being discarded).
  - mem_busy takes priority: freeze, go to MEM_WAIT. The remaining flush count is preserved and resumed on exit.
- MEM_WAIT:
  - Full freeze while mem_busy=1. Wait counter increments and saturates at 255.
  - When the counter reaches MAX_WAIT, mem_timeout sets; it clears only on RESET.
  - When mem_busy=0: stay frozen this cycle's evaluation is not needed — apply RUN rules in the same cycle, and next state follows them. If the preserved flush count is nonzero, return to BR_FLUSH instead.
  - A branch_taken_EX held during the freeze is acted on in the first unfrozen cycle, and only once.
- wrin_EX=0 never causes a stall.
- A reset asserted mid-stall or mid-flush aborts immediately; outputs return to their reset values asynchronously.

Optional Feature:
- HAZARD_STATS_EN defined: adds outputs stall_cnt, flush_cnt and wait_cnt (32 bits each). They count luh-stall cycles, flush cycles and freeze cycles respectively, wrap at 2^32, and clear on RESET.
- Not defined: the ports are absent and no counter logic is generated.

Decomposition:
- Package hazard_pkg: state enum hz_state_t {RUN, BR_FLUSH, MEM_WAIT} and the constant REG_ZERO=5'd0.
- Optional sub-module hazard_detect: the purely combinational luh compare, reusable by the forwarding unit.
- FSM, counters and output decode stay in hazard_ctrl.

Test Plan:
- Load-use: MemRead_EX=1, wrin_EX=5, rs1_ID=5, uses_rs1_ID=1 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead_EX=0) all writes=1.
- No false stall: same stimulus with wrin_EX=0, or uses_rs1_ID=0 -> no stall.
- Branch with FLUSH_CYCLES=3: branch_taken_EX pulse -> IF_ID_Flush=ID_EX_Flush=1 for exactly 3 cycles, state_o=1 for 2 of them, then state_o=0.
- Memory wait, MAX_WAIT=4: mem_busy high 6 cycles -> all *_Write=0 for 6 cycles, mem_timeout=1 after the 4th cycle and stays high; mem_busy low -> RUN.
- Simultaneous events: mem_busy=1 and branch_taken_EX=1 together -> freeze first; after mem_busy drops, flush is applied exactly once.
- Reset mid-flush: RESET=1 during BR_FLUSH -> state_o=0, flushes=0 without waiting for a clock edge.
